// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//
// Word-wide valid/ready external bus shared by the fetch and memory ports.
//
// Signals:
//   ext_address  32  word-aligned bus address           (master -> slave)
//   ext_wdata    32  lane-steered write data            (master -> slave)
//   ext_wstrb     4  byte write enables                 (master -> slave)
//   ext_write     1  1 = write, 0 = read                (master -> slave)
//   ext_valid     1  request valid                      (master -> slave)
//   ext_ready     1  completion, read data valid now    (slave -> master)
//   ext_rdata    32  read data                          (slave -> master)
// ---------------------------------------------------------------------------
interface bus_arbiter_if;
    logic [31:0] ext_address;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_wstrb;
    logic        ext_write;
    logic        ext_valid;
    logic        ext_ready;
    logic [31:0] ext_rdata;

    modport master (
        output ext_address,
        output ext_wdata,
        output ext_wstrb,
        output ext_write,
        output ext_valid,
        input  ext_ready,
        input  ext_rdata
    );

    modport slave (
        input  ext_address,
        input  ext_wdata,
        input  ext_wstrb,
        input  ext_write,
        input  ext_valid,
        output ext_ready,
        output ext_rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Shares one external valid/ready bus between the pipeline fetch port
// (read-only, always requesting) and the load/store memory port. Performs
// byte-lane steering for stores and byte/half extraction with optional sign
// extension for loads. Completion strobes are suppressed when the pipeline
// has changed its request since the grant (stale access).
//
// Parameters:
//   ROUND_ROBIN   0 = memory port always wins contention,
//                 1 = alternate grants when both ports contend in IDLE
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   fetch_address  in 32  instruction address
//   fetch_data     out 32 instruction word (valid with fetch_ready)
//   fetch_ready    out 1  one-cycle fetch completion strobe
//   mem_address    in 32  byte address of load/store
//   mem_store_data in 32  right-aligned store data
//   mem_size       in 2   0 = byte, 1 = half, 2/3 = word
//   mem_signed     in 1   sign-extend load data
//   mem_load       in 1   load request
//   mem_store      in 1   store request (wins over mem_load)
//   mem_load_data  out 32 extended load result (valid with mem_ready)
//   mem_ready      out 1  one-cycle memory completion strobe
//   bus            master side of the external bus
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          fetch_address,
    output logic [31:0]          fetch_data,
    output logic                 fetch_ready,
    input  logic [31:0]          mem_address,
    input  logic [31:0]          mem_store_data,
    input  logic [1:0]           mem_size,
    input  logic                 mem_signed,
    input  logic                 mem_load,
    input  logic                 mem_store,
    output logic [31:0]          mem_load_data,
    output logic                 mem_ready,
    bus_arbiter_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MEM   = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_MEM   = 1'b1
    } grant_e;

    state_e      state_q, state_d;
    grant_e      last_grant_q, last_grant_d;

    logic [31:0] lat_addr_q, lat_addr_d;
    logic [1:0]  lat_size_q, lat_size_d;
    logic        lat_signed_q, lat_signed_d;
    logic        lat_kind_q, lat_kind_d;

    logic [31:0] ext_address_q, ext_address_d;
    logic [31:0] ext_wdata_q, ext_wdata_d;
    logic [3:0]  ext_wstrb_q, ext_wstrb_d;
    logic        ext_write_q, ext_write_d;
    logic        ext_valid_q, ext_valid_d;

    logic        mem_req;
    logic        fetch_req;
    logic        grant_mem;
    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign mem_req   = mem_load | mem_store;
    // The fetch port has no request line: it is pending whenever the core
    // is out of reset.
    assign fetch_req = ~reset;

    // Memory wins unless round-robin is on and it was served last while
    // fetch is also waiting.
    assign grant_mem = mem_req &&
                       ((ROUND_ROBIN == 1'b0) ||
                        (last_grant_q == GRANT_FETCH) ||
                        !fetch_req);

    // Store lane steering: replicate the narrow datum across all lanes so
    // the strobe alone selects the target bytes.
    always_comb begin
        store_wstrb = 4'b1111;
        store_wdata = mem_store_data;
        case (mem_size)
            2'd0: begin
                store_wstrb = 4'b0001 << mem_address[1:0];
                store_wdata = {4{mem_store_data[7:0]}};
            end
            2'd1: begin
                store_wstrb = mem_address[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{mem_store_data[15:0]}};
            end
            default: begin
                store_wstrb = 4'b1111;
                store_wdata = mem_store_data;
            end
        endcase
    end

    // Next-state logic for the arbiter and its registered bus outputs.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        lat_addr_d    = lat_addr_q;
        lat_size_d    = lat_size_q;
        lat_signed_d  = lat_signed_q;
        lat_kind_d    = lat_kind_q;
        ext_address_d = ext_address_q;
        ext_wdata_d   = ext_wdata_q;
        ext_wstrb_d   = ext_wstrb_q;
        ext_write_d   = ext_write_q;
        ext_valid_d   = ext_valid_q;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d       = MEM;
                    lat_addr_d    = mem_address;
                    lat_size_d    = mem_size;
                    lat_signed_d  = mem_signed;
                    lat_kind_d    = mem_store;
                    ext_address_d = {mem_address[31:2], 2'b00};
                    ext_write_d   = mem_store;
                    ext_wstrb_d   = mem_store ? store_wstrb : 4'b0000;
                    ext_wdata_d   = mem_store ? store_wdata : 32'h0;
                    ext_valid_d   = 1'b1;
                end else if (fetch_req) begin
                    state_d       = FETCH;
                    lat_addr_d    = fetch_address;
                    lat_size_d    = 2'd2;
                    lat_signed_d  = 1'b0;
                    lat_kind_d    = 1'b0;
                    ext_address_d = {fetch_address[31:2], 2'b00};
                    ext_write_d   = 1'b0;
                    ext_wstrb_d   = 4'b0000;
                    ext_wdata_d   = 32'h0;
                    ext_valid_d   = 1'b1;
                end
            end
            FETCH, MEM: begin
                // Request stays on the bus until the slave accepts it; a
                // stale access still completes, only its strobe is dropped.
                if (bus.ext_ready) begin
                    ext_valid_d  = 1'b0;
                    state_d      = IDLE;
                    last_grant_d = (state_q == MEM) ? GRANT_MEM : GRANT_FETCH;
                end
            end
            default: begin
                state_d     = IDLE;
                ext_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_FETCH;
            lat_addr_q    <= 32'h0;
            lat_size_q    <= 2'd0;
            lat_signed_q  <= 1'b0;
            lat_kind_q    <= 1'b0;
            ext_address_q <= 32'h0;
            ext_wdata_q   <= 32'h0;
            ext_wstrb_q   <= 4'b0000;
            ext_write_q   <= 1'b0;
            ext_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            lat_addr_q    <= lat_addr_d;
            lat_size_q    <= lat_size_d;
            lat_signed_q  <= lat_signed_d;
            lat_kind_q    <= lat_kind_d;
            ext_address_q <= ext_address_d;
            ext_wdata_q   <= ext_wdata_d;
            ext_wstrb_q   <= ext_wstrb_d;
            ext_write_q   <= ext_write_d;
            ext_valid_q   <= ext_valid_d;
        end
    end

    assign bus.ext_address = ext_address_q;
    assign bus.ext_wdata   = ext_wdata_q;
    assign bus.ext_wstrb   = ext_wstrb_q;
    assign bus.ext_write   = ext_write_q;
    assign bus.ext_valid   = ext_valid_q;

    // Load extraction uses the offset latched at grant time, not the live
    // address, so the result matches the access actually on the bus.
    always_comb begin
        load_byte = bus.ext_rdata[7:0];
        case (lat_addr_q[1:0])
            2'd0:    load_byte = bus.ext_rdata[7:0];
            2'd1:    load_byte = bus.ext_rdata[15:8];
            2'd2:    load_byte = bus.ext_rdata[23:16];
            default: load_byte = bus.ext_rdata[31:24];
        endcase
        load_half = lat_addr_q[1] ? bus.ext_rdata[31:16] : bus.ext_rdata[15:0];

        mem_load_data = bus.ext_rdata;
        case (lat_size_q)
            2'd0:    mem_load_data = lat_signed_q ? {{24{load_byte[7]}}, load_byte}
                                                  : {24'h0, load_byte};
            2'd1:    mem_load_data = lat_signed_q ? {{16{load_half[15]}}, load_half}
                                                  : {16'h0, load_half};
            default: mem_load_data = bus.ext_rdata;
        endcase
    end

    assign fetch_data = bus.ext_rdata;

    // Strobes fire only if the pipeline still asks for the granted access.
    assign fetch_ready = !reset && (state_q == FETCH) && bus.ext_ready &&
                         (fetch_address == lat_addr_q);

    assign mem_ready = !reset && (state_q == MEM) && bus.ext_ready && mem_req &&
                       (mem_address == lat_addr_q) && (mem_store == lat_kind_q);

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one external word-wide valid/ready bus between the pipeline's fetch port (read-only) and memory port (load/store).
- Generates the `fetch_ready` and `mem_ready` strobes consumed by the hazard unit.
- Handles byte-lane steering for stores, and byte/half extraction with sign extension for loads.
- Sits between the pipeline top and the SoC bus, in place of the plain busio wiring.

Parameters:
- ROUND_ROBIN, 0, 0 = memory port always wins contention; 1 = alternate grants when both ports request in the same IDLE cycle.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_address  in  32  instruction address; the fetch request is always pending while reset is low
- fetch_data  out  32  instruction word, valid while `fetch_ready` = 1
- fetch_ready  out  1  one-cycle completion strobe for fetch
- mem_address  in  32  byte address of the load/store
- mem_store_data  in  32  store data, right-aligned
- mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word
- mem_signed  in  1  sign-extend load data
- mem_load  in  1  load request
- mem_store  in  1  store request
- mem_load_data  out  32  extended load result, valid while `mem_ready` = 1
- mem_ready  out  1  one-cycle completion strobe for the memory port
- ext_address  out  32  word-aligned bus address
- ext_wdata  out  32  lane-steered write data
- ext_wstrb  out  4  byte write enables
- ext_write  out  1  1 = write, 0 = read
- ext_valid  out  1  request valid
- ext_ready  in  1  slave completion; read data is valid in the same cycle
- ext_rdata  in  32  read data

Behaviour:
- Reset values (asynchronous, immediate): state = IDLE, `ext_valid` = 0, `ext_write` = 0, `ext_wstrb` = 0, `ext_address` = 0, `ext_wdata` = 0, `last_grant` = FETCH. `fetch_ready` and `mem_ready` = 0 while reset is high.
- Registered outputs: `ext_*` and the latched request copy (`lat_addr`, `lat_size`, `lat_signed`, `lat_kind`).
- Combinational outputs: `fetch_ready`, `mem_ready`, `fetch_data`, `mem_load_data`.
- State machine: IDLE, FETCH, MEM.
- IDLE:
  - `mem_req` = `mem_load` | `mem_store`.
  - If `mem_req` and (ROUND_ROBIN = 0 or `last_grant` = FETCH or no fetch request) -> MEM.
  - Otherwise -> FETCH. Fetch is always requesting out of reset.
  - On the transition, latch the request and drive `ext_valid` = 1 on the next edge.
  - Minimum access latency is 2 cycles: IDLE cycle, then the `ext_ready` cycle.
- FETCH/MEM:
  - Hold `ext_*` stable while `ext_ready` = 0; the AXI-lite-like rule is no withdrawal once valid.
  - On `ext_ready` = 1: deassert `ext_valid`, set `last_grant`, return to IDLE. Back-to-back issue resumes from IDLE.
- `ext_address` = {`addr[31:2]`, 2'b00}.
- Store steering by `mem_size`:
  - byte: `ext_wstrb` = 1 << `addr[1:0]`, `ext_wdata` = `data[7:0]` replicated ×4.
  - half: `ext_wstrb` = `addr[1]` ? 4'b1100 : 4'b0011, `ext_wdata` = `data[15:0]` replicated ×2.
  - word: `ext_wstrb` = 4'b1111, `ext_wdata` = data.
  - `mem_size` = 3 is treated as word. Misalignment is not checked: the half access uses `addr[1]` only; the word access ignores `addr[1:0]`.
- Reads drive `ext_wstrb` = 0 and `ext_write` = 0.
- Load extraction uses the latched offset:
  - byte: `ext_rdata` >> (8·off), low 8 bits.
  - half: `ext_rdata` >> (16·`off[1]`), low 16 bits.
  - Zero- or sign-extend per `lat_signed`.
- `fetch_data` = `ext_rdata` passthrough.
- Stale-request discard (pipeline invalidate/redirect mid-access):
  - `fetch_ready` = FETCH & `ext_ready` & (`fetch_address` == `lat_addr`).
  - `mem_ready` = MEM & `ext_ready` & `mem_req` & (`mem_address` == `lat_addr`) & (`mem_store` == `lat_kind`).
  - On mismatch the bus access still completes (stores take effect), no strobe is issued, and the FSM returns to IDLE and re-arbitrates the current request.
- Requests that change while the FSM is in IDLE are sampled fresh; no capture before the grant.
- Reset mid-access abandons the bus transaction: `ext_valid` drops immediately and the slave must tolerate this.
- `mem_load` & `mem_store` both high: treated as a store.

Test Plan:
- Fetch only, `fetch_address` = 0x100, slave `ext_ready` after 1 wait cycle, `ext_rdata` = 0x00500093 -> `ext_address` = 0x100, `ext_write` = 0; `fetch_ready` pulses 1 cycle with `fetch_data` = 0x00500093; the next access starts 1 cycle later.
- Store byte 0xAB to 0x203 -> `ext_address` = 0x200, `ext_wstrb` = 4'b1000, `ext_wdata` = 0xABABABAB, `ext_write` = 1; `mem_ready` on `ext_ready`. Store half 0x1234 to 0x202 -> `ext_wstrb` = 4'b1100, `ext_wdata` = 0x12341234.
- Loads from 0x301 with `ext_rdata` = 0x80F0FF7F:
  - signed byte -> `mem_load_data` = 0xFFFFFFFF.
  - unsigned byte -> 0x000000FF.
  - signed half @0x302 -> 0xFFFF80F0.
  - word @0x300 -> 0x80F0FF7F.
- Contention: fetch and load both pending in IDLE.
  - ROUND_ROBIN = 0 -> MEM granted first, FETCH next.
  - ROUND_ROBIN = 1 with two consecutive contended rounds -> grants alternate MEM, FETCH, MEM, FETCH.
- Stale fetch: `fetch_address` changes 0x100 -> 0x400 while FETCH waits on `ext_ready` -> no `fetch_ready` at completion; a new access to 0x400 follows and strobes normally.
- Assert reset while MEM has `ext_valid` = 1 -> `ext_valid` = 0 in the same cycle, no `mem_ready`; after release the FSM is in IDLE and the first grant is MEM if a load is pending.
